// File: rtl/reg_block_param.sv
// Parametrised register file with two read ports, one write port,
// exported one-hot decoders, optional write bypass and a dirty mask.
module reg_block_param #(
    parameter  int DW      = 16,
    parameter  int AW      = 3,
    parameter  int BYPASS  = 1,
    parameter  int R0_ZERO = 0,
    localparam int NREG    = 2**AW
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic            We,
    input  logic [AW-1:0]   RwIn,
    input  logic [DW-1:0]   WData,
    input  logic [AW-1:0]   Rs1In,
    input  logic [AW-1:0]   Rs2In,
    input  logic            Clr,
    output logic [NREG-1:0] Rs1,
    output logic [NREG-1:0] Rs2,
    output logic [NREG-1:0] Rw,
    output logic [DW-1:0]   Rs1Data,
    output logic [DW-1:0]   Rs2Data,
    output logic [NREG-1:0] Dirty
);

    localparam logic [NREG-1:0] ONE = NREG'(1);

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] dirty_q;
    logic [NREG-1:0] dirty_d;
    logic [NREG-1:0] wr_sel;

    assign Rs1 = ONE << Rs1In;
    assign Rs2 = ONE << Rs2In;
    assign Rw  = We ? (ONE << RwIn) : '0;

    // Rw still shows bit 0; only the storage/dirty path drops it.
    always_comb begin
        wr_sel = Rw;
        if (R0_ZERO != 0) begin
            wr_sel[0] = 1'b0;
        end
    end

    assign dirty_d = (Clr ? '0 : dirty_q) | wr_sel;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            dirty_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            dirty_q <= dirty_d;
            for (int i = 0; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= WData;
                end
            end
        end
    end

    always_comb begin
        Rs1Data = regs_q[Rs1In];
        if (BYPASS != 0 && We && RwIn == Rs1In) begin
            Rs1Data = WData;
        end
        if (R0_ZERO != 0 && Rs1In == '0) begin
            Rs1Data = '0;
        end
    end

    always_comb begin
        Rs2Data = regs_q[Rs2In];
        if (BYPASS != 0 && We && RwIn == Rs2In) begin
            Rs2Data = WData;
        end
        if (R0_ZERO != 0 && Rs2In == '0) begin
            Rs2Data = '0;
        end
    end

    assign Dirty = dirty_q;

endmodule

// File: tb/tb_reg_block_param.sv
// Directed bench for reg_block_param: a default instance (bypass on)
// and a second one with bypass off and register 0 hardwired to zero.
module tb_reg_block_param;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        We;
    logic [2:0]  RwIn;
    logic [15:0] WData;
    logic [2:0]  Rs1In;
    logic [2:0]  Rs2In;
    logic        Clr;

    logic [7:0]  a_rs1, a_rs2, a_rw, a_dirty;
    logic [15:0] a_d1, a_d2;
    logic [7:0]  b_rs1, b_rs2, b_rw, b_dirty;
    logic [15:0] b_d1, b_d2;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    reg_block_param u_a (
        .Clock(Clock), .nReset(nReset), .We(We), .RwIn(RwIn),
        .WData(WData), .Rs1In(Rs1In), .Rs2In(Rs2In), .Clr(Clr),
        .Rs1(a_rs1), .Rs2(a_rs2), .Rw(a_rw),
        .Rs1Data(a_d1), .Rs2Data(a_d2), .Dirty(a_dirty)
    );

    reg_block_param #(.BYPASS(0), .R0_ZERO(1)) u_b (
        .Clock(Clock), .nReset(nReset), .We(We), .RwIn(RwIn),
        .WData(WData), .Rs1In(Rs1In), .Rs2In(Rs2In), .Clr(Clr),
        .Rs1(b_rs1), .Rs2(b_rs2), .Rw(b_rw),
        .Rs1Data(b_d1), .Rs2Data(b_d2), .Dirty(b_dirty)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        We = 0; RwIn = 0; WData = 0; Rs1In = 0; Rs2In = 0; Clr = 0;
        step(); step();
        #2 nReset = 1'b1;
        #1;
        tests++;
        if (a_dirty !== 8'h00 || b_dirty !== 8'h00) begin
            fails++;
            $display("FAIL reset_dirty: got %h/%h want 00", a_dirty, b_dirty);
        end
        for (int i = 0; i < 8; i++) begin
            Rs1In = 3'(i);
            Rs2In = 3'(7 - i);
            #1;
            tests++;
            if (a_rs1 !== 8'(1 << i) || b_rs1 !== 8'(1 << i)) begin
                fails++;
                $display("FAIL sweep_rs1[%0d]: got %h/%h want %h",
                         i, a_rs1, b_rs1, 8'(1 << i));
            end
            tests++;
            if (a_rs2 !== 8'(1 << (7 - i)) || b_rs2 !== 8'(1 << (7 - i))) begin
                fails++;
                $display("FAIL sweep_rs2[%0d]: got %h/%h want %h",
                         i, a_rs2, b_rs2, 8'(1 << (7 - i)));
            end
            tests++;
            if (a_rw !== 8'h00 || b_rw !== 8'h00) begin
                fails++;
                $display("FAIL sweep_rw[%0d]: got %h/%h want 00", i, a_rw, b_rw);
            end
            tests++;
            if (a_d1 !== 16'h0 || a_d2 !== 16'h0 || b_d1 !== 16'h0 || b_d2 !== 16'h0) begin
                fails++;
                $display("FAIL sweep_data[%0d]: got %h %h %h %h want 0",
                         i, a_d1, a_d2, b_d1, b_d2);
            end
        end
    endtask

    task automatic test_write_all();
        logic [15:0] ea1, ea2, eb1, eb2;
        for (int i = 0; i < 8; i++) begin
            We = 1'b1;
            RwIn = 3'(i);
            WData = 16'hA5A0 + 16'(i);
            #1;
            tests++;
            if (a_rw !== 8'(1 << i) || b_rw !== 8'(1 << i)) begin
                fails++;
                $display("FAIL write_rw[%0d]: got %h/%h want %h",
                         i, a_rw, b_rw, 8'(1 << i));
            end
            step();
        end
        We = 1'b0;
        for (int i = 0; i < 8; i++) begin
            Rs1In = 3'(i);
            Rs2In = 3'(7 - i);
            #1;
            ea1 = 16'hA5A0 + 16'(i);
            ea2 = 16'hA5A0 + 16'(7 - i);
            eb1 = (i == 0) ? 16'h0 : ea1;
            eb2 = (i == 7) ? 16'h0 : ea2;
            tests++;
            if (a_d1 !== ea1 || a_d2 !== ea2) begin
                fails++;
                $display("FAIL readback_a[%0d]: got %h %h want %h %h",
                         i, a_d1, a_d2, ea1, ea2);
            end
            tests++;
            if (b_d1 !== eb1 || b_d2 !== eb2) begin
                fails++;
                $display("FAIL readback_b[%0d]: got %h %h want %h %h",
                         i, b_d1, b_d2, eb1, eb2);
            end
        end
        tests++;
        if (a_dirty !== 8'hFF) begin
            fails++;
            $display("FAIL dirty_all_a: got %h want ff", a_dirty);
        end
        tests++;
        if (b_dirty !== 8'hFE) begin
            fails++;
            $display("FAIL dirty_all_b: got %h want fe", b_dirty);
        end
    endtask

    task automatic test_bypass();
        We = 1'b1; RwIn = 3'd5; WData = 16'h1234;
        Rs1In = 3'd5; Rs2In = 3'd5;
        #1;
        tests++;
        if (a_d1 !== 16'h1234 || a_d2 !== 16'h1234) begin
            fails++;
            $display("FAIL bypass_on: got %h %h want 1234", a_d1, a_d2);
        end
        tests++;
        if (b_d1 !== 16'hA5A5 || b_d2 !== 16'hA5A5) begin
            fails++;
            $display("FAIL bypass_off_old: got %h %h want a5a5", b_d1, b_d2);
        end
        step();
        We = 1'b0;
        #1;
        tests++;
        if (a_d1 !== 16'h1234 || b_d1 !== 16'h1234 || b_d2 !== 16'h1234) begin
            fails++;
            $display("FAIL bypass_next: got %h %h %h want 1234", a_d1, b_d1, b_d2);
        end
    endtask

    task automatic test_clr_we();
        Clr = 1'b1; We = 1'b1; RwIn = 3'd2; WData = 16'h2222;
        step();
        Clr = 1'b0; We = 1'b0;
        #1;
        tests++;
        if (a_dirty !== 8'h04 || b_dirty !== 8'h04) begin
            fails++;
            $display("FAIL clr_we: got %h/%h want 04", a_dirty, b_dirty);
        end
    endtask

    task automatic test_r0();
        We = 1'b1; RwIn = 3'd0; WData = 16'hFFFF;
        Rs1In = 3'd0; Rs2In = 3'd0;
        #1;
        tests++;
        if (b_rw !== 8'h01 || a_rw !== 8'h01) begin
            fails++;
            $display("FAIL r0_rw: got %h/%h want 01", a_rw, b_rw);
        end
        tests++;
        if (b_d1 !== 16'h0 || a_d1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL r0_same_cycle: got %h/%h want ffff/0000", a_d1, b_d1);
        end
        step();
        We = 1'b0;
        #1;
        tests++;
        if (b_d1 !== 16'h0 || b_d2 !== 16'h0 || a_d1 !== 16'hFFFF) begin
            fails++;
            $display("FAIL r0_after: got a=%h b=%h %h want ffff/0/0", a_d1, b_d1, b_d2);
        end
        tests++;
        if (b_dirty !== 8'h04 || a_dirty !== 8'h05) begin
            fails++;
            $display("FAIL r0_dirty: got %h/%h want 05/04", a_dirty, b_dirty);
        end
    endtask

    task automatic test_async_reset();
        We = 1'b1; RwIn = 3'd6; WData = 16'hBEEF;
        Rs1In = 3'd1; Rs2In = 3'd3;
        #2 nReset = 1'b0;
        #1;
        tests++;
        if (a_d1 !== 16'h0 || a_d2 !== 16'h0 || b_d1 !== 16'h0 || b_d2 !== 16'h0) begin
            fails++;
            $display("FAIL areset_data: got %h %h %h %h want 0", a_d1, a_d2, b_d1, b_d2);
        end
        tests++;
        if (a_dirty !== 8'h00 || b_dirty !== 8'h00) begin
            fails++;
            $display("FAIL areset_dirty: got %h/%h want 00", a_dirty, b_dirty);
        end
        step();
        We = 1'b0;
        #2 nReset = 1'b1;
        Rs1In = 3'd6; Rs2In = 3'd2;
        #1;
        tests++;
        if (a_d1 !== 16'h0 || b_d1 !== 16'h0 || a_d2 !== 16'h0 || b_d2 !== 16'h0) begin
            fails++;
            $display("FAIL areset_lost_write: got %h %h %h %h want 0",
                     a_d1, b_d1, a_d2, b_d2);
        end
    endtask

    initial begin
        test_reset();
        test_write_all();
        test_bypass();
        test_clr_we();
        test_r0();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
